// File: rtl/minilab0_top_if.sv
// Board I/O bundle for Minilab0: push-buttons, switches, LEDs and the six
// 7-segment displays. The board top takes the slave view; the environment
// driving the buttons and switches takes the master view.
interface minilab0_top_if;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic [9:0] LEDR;
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [6:0] HEX2;
    logic [6:0] HEX3;
    logic [6:0] HEX4;
    logic [6:0] HEX5;

    modport master (
        output KEY, SW,
        input  LEDR, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
    );

    modport slave (
        input  KEY, SW,
        output LEDR, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
    );
endinterface

// File: rtl/minilab0_top.sv
// Minilab0 board top: fills two 8-deep FIFOs with fixed operand sequences,
// drains them in lockstep into a multiply-accumulate unit, and shows the
// 24-bit dot product on HEX5..HEX0 once finished (gated by SW[0]).
// LEDR[1:0] mirrors the control FSM state.

// Synchronous FIFO with one-cycle read latency. Pushes while full and pops
// while empty are dropped; dout only changes on an accepted pop.
module minilab0_fifo #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wren,
    input  logic                  rden,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = dout_q;

    // Accept/reject push and pop, advance pointers with wrap, track occupancy.
    always_comb begin
        do_push  = wren && !full;
        do_pop   = rden && !empty;
        mem_d    = mem_q;
        dout_d   = dout_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            dout_d   = mem_q[rd_ptr_q];
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state: pointers and occupancy are cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage and read register carry no reset; occupancy guards their use.
    always_ff @(posedge clk) begin
        mem_q  <= mem_d;
        dout_q <= dout_d;
    end
endmodule

module minilab0_top #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24
) (
    input  logic           CLOCK_50,
    input  logic           CLOCK2_50,
    input  logic           CLOCK3_50,
    input  logic           CLOCK4_50,
    minilab0_top_if.slave  bus
);
    localparam int IW = $clog2(DEPTH + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        EXEC = 2'd2,
        DONE = 2'd3
    } state_t;

    // Active-low push-button becomes the active-high synchronous reset.
    logic rst;
    assign rst = ~bus.KEY[0];

    // Board inputs with no function in this lab.
    logic unused_inputs;
    assign unused_inputs = ^{CLOCK2_50, CLOCK3_50, CLOCK4_50, bus.KEY[3:1], bus.SW[9:1]};

    // 7-segment encoding, active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'h0:    seg7 = 7'h40;
            4'h1:    seg7 = 7'h79;
            4'h2:    seg7 = 7'h24;
            4'h3:    seg7 = 7'h30;
            4'h4:    seg7 = 7'h19;
            4'h5:    seg7 = 7'h12;
            4'h6:    seg7 = 7'h02;
            4'h7:    seg7 = 7'h78;
            4'h8:    seg7 = 7'h00;
            4'h9:    seg7 = 7'h10;
            4'hA:    seg7 = 7'h08;
            4'hB:    seg7 = 7'h03;
            4'hC:    seg7 = 7'h46;
            4'hD:    seg7 = 7'h21;
            4'hE:    seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    // One MAC step: zero-extended product, accumulator wraps at ACC_WIDTH bits.
    function automatic logic [ACC_WIDTH-1:0] mac_add(
        input logic [ACC_WIDTH-1:0]  acc,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [2*DATA_WIDTH-1:0] prod;
        prod = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
        return acc + ACC_WIDTH'(prod);
    endfunction

    state_t                state_q, state_d;
    logic [IW-1:0]         fill_idx_q, fill_idx_d;
    logic                  en_q, en_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;

    logic                  wren, rden;
    logic [DATA_WIDTH-1:0] din_a, din_b;
    logic [DATA_WIDTH-1:0] dout_a, dout_b;
    logic                  full_a, full_b, empty_a, empty_b;

    // Operand sequences: A[i] = i+1, B[i] = i+10.
    assign din_a = DATA_WIDTH'(fill_idx_q) + DATA_WIDTH'(1);
    assign din_b = DATA_WIDTH'(fill_idx_q) + DATA_WIDTH'(10);

    minilab0_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_fifo_a (
        .clk   (CLOCK_50),
        .rst   (rst),
        .wren  (wren),
        .rden  (rden),
        .din   (din_a),
        .dout  (dout_a),
        .full  (full_a),
        .empty (empty_a)
    );

    minilab0_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_fifo_b (
        .clk   (CLOCK_50),
        .rst   (rst),
        .wren  (wren),
        .rden  (rden),
        .din   (din_b),
        .dout  (dout_b),
        .full  (full_b),
        .empty (empty_b)
    );

    // Control FSM: push every FILL cycle (the FIFO drops the push that lands
    // while full), pop in EXEC until empty, finish once the last product
    // delivered by the final pop has been accumulated.
    always_comb begin
        state_d    = state_q;
        fill_idx_d = fill_idx_q;
        wren       = 1'b0;
        rden       = 1'b0;
        case (state_q)
            IDLE: state_d = FILL;
            FILL: begin
                wren       = 1'b1;
                fill_idx_d = fill_idx_q + IW'(1);
                if (full_a && full_b) state_d = EXEC;
            end
            EXEC: begin
                rden = !empty_a && !empty_b;
                if (empty_a && empty_b && !en_q) state_d = DONE;
            end
            default: state_d = DONE;
        endcase
    end

    // MAC enable follows rden by one cycle so it lines up with FIFO dout.
    always_comb begin
        en_d  = rden;
        acc_d = en_q ? mac_add(acc_q, dout_a, dout_b) : acc_q;
    end

    // State, fill index and MAC registers; reset aborts any run in progress.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state_q    <= IDLE;
            fill_idx_q <= '0;
            en_q       <= 1'b0;
            acc_q      <= '0;
        end else begin
            state_q    <= state_d;
            fill_idx_q <= fill_idx_d;
            en_q       <= en_d;
            acc_q      <= acc_d;
        end
    end

    // Display is live only when enabled by SW[0] and the result is final.
    logic disp_on;
    assign disp_on = bus.SW[0] && (state_q == DONE);

    assign bus.HEX0 = disp_on ? seg7(acc_q[3:0])   : 7'h7F;
    assign bus.HEX1 = disp_on ? seg7(acc_q[7:4])   : 7'h7F;
    assign bus.HEX2 = disp_on ? seg7(acc_q[11:8])  : 7'h7F;
    assign bus.HEX3 = disp_on ? seg7(acc_q[15:12]) : 7'h7F;
    assign bus.HEX4 = disp_on ? seg7(acc_q[19:16]) : 7'h7F;
    assign bus.HEX5 = disp_on ? seg7(acc_q[23:20]) : 7'h7F;

    assign bus.LEDR = {8'b0, state_q};
endmodule

// File: tb/tb_minilab0_top.sv
// Directed bench for minilab0_top: full run, display, FIFO boundaries,
// mid-run reset and rerun, with unused inputs toggling throughout.
module tb_minilab0_top;
    logic CLOCK_50  = 1'b0;
    logic CLOCK2_50 = 1'b0;
    logic CLOCK3_50 = 1'b0;
    logic CLOCK4_50 = 1'b0;

    minilab0_top_if bus_if ();

    minilab0_top dut (
        .CLOCK_50  (CLOCK_50),
        .CLOCK2_50 (CLOCK2_50),
        .CLOCK3_50 (CLOCK3_50),
        .CLOCK4_50 (CLOCK4_50),
        .bus       (bus_if)
    );

    always #10 CLOCK_50  = ~CLOCK_50;
    always #7  CLOCK2_50 = ~CLOCK2_50;
    always #13 CLOCK3_50 = ~CLOCK3_50;
    always #3  CLOCK4_50 = ~CLOCK4_50;

    int vectors     = 0;
    int miscompares = 0;
    int cyc_count   = 0;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        bus_if.SW[9:1]  = 9'($urandom);
        bus_if.KEY[3:1] = 3'($urandom);
        cyc_count++;
    endtask

    task automatic wait_done();
        while (bus_if.LEDR[1:0] != 2'd3 && cyc_count < 30) step();
        check_vec("done_reached", 32'(bus_if.LEDR[1:0]), 32'd3);
        check_vec("done_latency_le_24", 32'(cyc_count <= 24), 32'd1);
    endtask

    initial begin
        bus_if.KEY = 4'b1110;
        bus_if.SW  = 10'h001;

        // Reset state
        step();
        check_vec("rst_ledr", 32'(bus_if.LEDR), 32'd0);
        check_vec("rst_hex0", 32'(bus_if.HEX0), 32'h7F);
        check_vec("rst_hex5", 32'(bus_if.HEX5), 32'h7F);
        check_vec("rst_acc", 32'(dut.acc_q), 32'd0);
        check_vec("rst_cnt_a", 32'(dut.u_fifo_a.count_q), 32'd0);
        check_vec("rst_empty_b", 32'(dut.u_fifo_b.empty), 32'd1);

        // Release; first edge moves IDLE -> FILL
        bus_if.KEY[0] = 1'b1;
        cyc_count = 0;
        step();
        check_vec("state_fill", 32'(bus_if.LEDR[1:0]), 32'd1);

        // Eight pushes; full exactly after the eighth
        for (int k = 0; k < 8; k++) begin
            step();
            check_vec("fill_cnt_a", 32'(dut.u_fifo_a.count_q), 32'(k + 1));
            check_vec("fill_full_a", 32'(dut.u_fifo_a.full), 32'(k == 7));
            check_vec("fill_full_b", 32'(dut.u_fifo_b.full), 32'(k == 7));
        end
        check_vec("fill_state_still", 32'(bus_if.LEDR[1:0]), 32'd1);

        // Next edge: FILL -> EXEC; the push landing on a full FIFO is dropped
        step();
        check_vec("state_exec", 32'(bus_if.LEDR[1:0]), 32'd2);
        check_vec("full_push_cnt", 32'(dut.u_fifo_a.count_q), 32'd8);
        check_vec("full_push_mem0", 32'(dut.u_fifo_a.mem_q[0]), 32'd1);
        check_vec("full_push_mem0_b", 32'(dut.u_fifo_b.mem_q[0]), 32'd10);

        // Pops: dout one cycle after each rden
        for (int k = 0; k < 8; k++) begin
            step();
            check_vec("dout_a", 32'(dut.u_fifo_a.dout), 32'(k + 1));
            check_vec("dout_b", 32'(dut.u_fifo_b.dout), 32'(k + 10));
        end
        check_vec("empty_a", 32'(dut.u_fifo_a.empty), 32'd1);
        check_vec("empty_b", 32'(dut.u_fifo_b.empty), 32'd1);
        step();
        check_vec("dout_hold_a", 32'(dut.u_fifo_a.dout), 32'd8);
        check_vec("dout_hold_b", 32'(dut.u_fifo_b.dout), 32'd17);

        wait_done();
        check_vec("acc_final", 32'(dut.acc_q), 32'h000210);
        check_vec("dout_hold_done", 32'(dut.u_fifo_a.dout), 32'd8);
        check_vec("cnt_done", 32'(dut.u_fifo_a.count_q), 32'd0);

        // Display on
        check_vec("hex0", 32'(bus_if.HEX0), 32'h40);
        check_vec("hex1", 32'(bus_if.HEX1), 32'h79);
        check_vec("hex2", 32'(bus_if.HEX2), 32'h24);
        check_vec("hex3", 32'(bus_if.HEX3), 32'h40);
        check_vec("hex4", 32'(bus_if.HEX4), 32'h40);
        check_vec("hex5", 32'(bus_if.HEX5), 32'h40);

        // Display off is combinational
        bus_if.SW[0] = 1'b0;
        #1;
        check_vec("hex0_off", 32'(bus_if.HEX0), 32'h7F);
        check_vec("hex1_off", 32'(bus_if.HEX1), 32'h7F);
        check_vec("hex2_off", 32'(bus_if.HEX2), 32'h7F);
        check_vec("hex5_off", 32'(bus_if.HEX5), 32'h7F);
        step();
        check_vec("done_holds", 32'(bus_if.LEDR[1:0]), 32'd3);
        check_vec("acc_sw_off", 32'(dut.acc_q), 32'h000210);
        bus_if.SW[0] = 1'b1;

        // Fresh run, then reset midway through EXEC
        bus_if.KEY[0] = 1'b0;
        step();
        bus_if.KEY[0] = 1'b1;
        cyc_count = 0;
        while (bus_if.LEDR[1:0] != 2'd2 && cyc_count < 30) step();
        check_vec("rerun_exec", 32'(bus_if.LEDR[1:0]), 32'd2);
        step();
        step();
        step();
        check_vec("mid_acc_nonzero", 32'(dut.acc_q != 0), 32'd1);
        bus_if.KEY[0] = 1'b0;
        step();
        check_vec("abort_state", 32'(bus_if.LEDR), 32'd0);
        check_vec("abort_acc", 32'(dut.acc_q), 32'd0);
        check_vec("abort_hex0", 32'(bus_if.HEX0), 32'h7F);
        check_vec("abort_cnt", 32'(dut.u_fifo_a.count_q), 32'd0);

        // Rerun after abort
        bus_if.KEY[0] = 1'b1;
        cyc_count = 0;
        wait_done();
        check_vec("rerun_acc", 32'(dut.acc_q), 32'h000210);
        check_vec("rerun_hex1", 32'(bus_if.HEX1), 32'h79);
        check_vec("rerun_hex2", 32'(bus_if.HEX2), 32'h24);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
